// File: rtl/midi_voice_alloc_pkg.sv
// Shared constants and types for the MIDI voice allocator.
// Holds the payload width and voice-count limits used across the allocator files.
package midi_voice_alloc_pkg;

    localparam int unsigned MidiPayloadBits = 7;
    localparam int unsigned MidiMaxVoices   = 8;
    localparam int unsigned VoiceIdxBits    = $clog2(MidiMaxVoices);

    // Which note-on rule picked the target voice.
    typedef enum logic [1:0] {
        SelNone,
        SelMatch,
        SelFree,
        SelSteal
    } sel_e;

endpackage

// File: rtl/voice_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module voice_prio_enc #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned IDX_BITS = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    req,
    output logic [IDX_BITS-1:0] idx,
    output logic                valid
);

    // Scan high to low so the lowest set bit is written last and wins.
    always_comb begin
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_BITS'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice scheduler: maps note-on/off strobes onto voice slots,
// reusing matching voices, filling free ones, and stealing the LRU voice.
module midi_voice_alloc
    import midi_voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_BITS   = $clog2(NUM_VOICES)
) (
    input  logic                                  clk_i,
    input  logic                                  nrst_i,
    input  logic [MidiPayloadBits-1:0]            note_i,
    input  logic                                  noteOnStrb_i,
    input  logic                                  noteOffStrb_i,
    input  logic                                  allOff_i,
    output logic [NUM_VOICES*MidiPayloadBits-1:0] voiceNote_o,
    output logic [NUM_VOICES-1:0]                 voiceGate_o,
    output logic [NUM_VOICES-1:0]                 voiceTrig_o,
    output logic                                  stealStrb_o
);

    logic [MidiPayloadBits-1:0] note_q [NUM_VOICES];
    logic [MidiPayloadBits-1:0] note_d [NUM_VOICES];
    logic [AGE_BITS-1:0]        age_q  [NUM_VOICES];
    logic [AGE_BITS-1:0]        age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0]      gate_q, gate_d;
    logic [NUM_VOICES-1:0]      trig_q, trig_d;
    logic                       steal_q, steal_d;

    logic [NUM_VOICES-1:0] match_vec, free_vec, old_vec;
    logic [AGE_BITS-1:0]   match_idx, free_idx, old_idx, target;
    logic                  match_valid, free_valid, old_valid;
    sel_e                  sel;

    // Only sounding voices count as a match; stale notes of released voices do not.
    always_comb begin
        for (int k = 0; k < int'(NUM_VOICES); k++) begin
            match_vec[k] = gate_q[k] && (note_q[k] == note_i);
            old_vec[k]   = (age_q[k] == AGE_BITS'(NUM_VOICES - 1));
        end
    end

    assign free_vec = ~gate_q;

    voice_prio_enc #(.WIDTH(NUM_VOICES), .IDX_BITS(AGE_BITS)) u_match_enc (
        .req   (match_vec),
        .idx   (match_idx),
        .valid (match_valid)
    );

    voice_prio_enc #(.WIDTH(NUM_VOICES), .IDX_BITS(AGE_BITS)) u_free_enc (
        .req   (free_vec),
        .idx   (free_idx),
        .valid (free_valid)
    );

    voice_prio_enc #(.WIDTH(NUM_VOICES), .IDX_BITS(AGE_BITS)) u_old_enc (
        .req   (old_vec),
        .idx   (old_idx),
        .valid (old_valid)
    );

    always_comb begin
        sel    = SelNone;
        target = '0;
        if (noteOnStrb_i && !allOff_i) begin
            if (match_valid) begin
                sel = SelMatch;
            end else if (free_valid) begin
                sel = SelFree;
            end else if (old_valid) begin
                sel = SelSteal;
            end
        end
        case (sel)
            SelMatch: target = match_idx;
            SelFree:  target = free_idx;
            SelSteal: target = old_idx;
            default:  target = '0;
        endcase
    end

    always_comb begin
        note_d  = note_q;
        age_d   = age_q;
        gate_d  = gate_q;
        trig_d  = '0;
        steal_d = 1'b0;
        if (allOff_i) begin
            gate_d = '0;
        end else if (sel != SelNone) begin
            note_d[target] = note_i;
            gate_d[target] = 1'b1;
            trig_d[target] = 1'b1;
            steal_d        = (sel == SelSteal);
            // Voices younger than the target age by one; older ones keep their slot.
            for (int k = 0; k < int'(NUM_VOICES); k++) begin
                if (age_q[k] < age_q[target]) begin
                    age_d[k] = age_q[k] + 1'b1;
                end
            end
            age_d[target] = '0;
        end else if (noteOffStrb_i && match_valid) begin
            gate_d[match_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            for (int k = 0; k < int'(NUM_VOICES); k++) begin
                note_q[k] <= '0;
                age_q[k]  <= AGE_BITS'(k);
            end
            gate_q  <= '0;
            trig_q  <= '0;
            steal_q <= 1'b0;
        end else begin
            note_q  <= note_d;
            age_q   <= age_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            steal_q <= steal_d;
        end
    end

    for (genvar k = 0; k < NUM_VOICES; k++) begin : g_note_out
        assign voiceNote_o[k*MidiPayloadBits +: MidiPayloadBits] = note_q[k];
    end

    assign voiceGate_o = gate_q;
    assign voiceTrig_o = trig_q;
    assign stealStrb_o = steal_q;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed self-checking bench for midi_voice_alloc with four voices.
module tb_midi_voice_alloc;

    logic        clk_i = 1'b0;
    logic        nrst_i = 1'b0;
    logic [6:0]  note_i = '0;
    logic        noteOnStrb_i = 1'b0;
    logic        noteOffStrb_i = 1'b0;
    logic        allOff_i = 1'b0;
    logic [27:0] voiceNote_o;
    logic [3:0]  voiceGate_o;
    logic [3:0]  voiceTrig_o;
    logic        stealStrb_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    midi_voice_alloc #(.NUM_VOICES(4)) dut (
        .clk_i         (clk_i),
        .nrst_i        (nrst_i),
        .note_i        (note_i),
        .noteOnStrb_i  (noteOnStrb_i),
        .noteOffStrb_i (noteOffStrb_i),
        .allOff_i      (allOff_i),
        .voiceNote_o   (voiceNote_o),
        .voiceGate_o   (voiceGate_o),
        .voiceTrig_o   (voiceTrig_o),
        .stealStrb_o   (stealStrb_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6:0] vn(input int k);
        return voiceNote_o[k*7 +: 7];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ev(input logic on, input logic off, input logic [6:0] n);
        note_i        = n;
        noteOnStrb_i  = on;
        noteOffStrb_i = off;
        tick();
        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
    endtask

    task automatic do_reset();
        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
        allOff_i      = 1'b0;
        nrst_i        = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        nrst_i = 1'b1;
    endtask

    task automatic fill4(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
        ev(1'b1, 1'b0, a);
        ev(1'b1, 1'b0, b);
        ev(1'b1, 1'b0, c);
        ev(1'b1, 1'b0, d);
    endtask

    task automatic test_reset();
        nrst_i = 1'b0;
        #3;
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o, stealStrb_o} !== 9'd0)
            $display("FAIL reset_ctrl: got %b, expected 0", {voiceGate_o, voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        total_cnt++;
        if (voiceNote_o !== 28'd0)
            $display("FAIL reset_notes: got %h, expected 0", voiceNote_o);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_first_note();
        do_reset();
        ev(1'b1, 1'b0, 7'd60);
        total_cnt++;
        if (vn(0) !== 7'd60) $display("FAIL first_note: got %0d, expected 60", vn(0));
        else pass_cnt++;
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o, stealStrb_o} !== {4'b0001, 4'b0001, 1'b0})
            $display("FAIL first_ctrl: got %b, expected 000100010",
                     {voiceGate_o, voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (voiceTrig_o !== 4'b0000) $display("FAIL trig_one_cycle: got %b, expected 0000", voiceTrig_o);
        else pass_cnt++;
    endtask

    task automatic test_free_reuse();
        do_reset();
        fill4(7'd60, 7'd62, 7'd64, 7'd65);
        ev(1'b0, 1'b1, 7'd62);
        total_cnt++;
        if (voiceGate_o !== 4'b1101) $display("FAIL off_gate: got %b, expected 1101", voiceGate_o);
        else pass_cnt++;
        total_cnt++;
        if (vn(1) !== 7'd62) $display("FAIL off_note_kept: got %0d, expected 62", vn(1));
        else pass_cnt++;
        ev(1'b1, 1'b0, 7'd67);
        total_cnt++;
        if ({voiceTrig_o, voiceGate_o, stealStrb_o} !== {4'b0010, 4'b1111, 1'b0})
            $display("FAIL reuse_free: got %b, expected 001011110",
                     {voiceTrig_o, voiceGate_o, stealStrb_o});
        else pass_cnt++;
        total_cnt++;
        if (vn(1) !== 7'd67) $display("FAIL reuse_note: got %0d, expected 67", vn(1));
        else pass_cnt++;
    endtask

    task automatic test_steal();
        do_reset();
        fill4(7'd60, 7'd62, 7'd64, 7'd65);
        ev(1'b1, 1'b0, 7'd70);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o, voiceGate_o} !== {4'b0001, 1'b1, 4'b1111})
            $display("FAIL steal_v0: got %b, expected 000111111",
                     {voiceTrig_o, stealStrb_o, voiceGate_o});
        else pass_cnt++;
        total_cnt++;
        if (vn(0) !== 7'd70) $display("FAIL steal_note: got %0d, expected 70", vn(0));
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stealStrb_o !== 1'b0) $display("FAIL steal_one_cycle: got %b, expected 0", stealStrb_o);
        else pass_cnt++;
        // Ages now v0=0 v1=3 v2=2 v3=1, so steals should walk v1 then v2.
        ev(1'b1, 1'b0, 7'd71);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o} !== {4'b0010, 1'b1})
            $display("FAIL steal_lru2: got %b, expected 00101", {voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        ev(1'b1, 1'b0, 7'd73);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o} !== {4'b0100, 1'b1})
            $display("FAIL steal_lru3: got %b, expected 01001", {voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        total_cnt++;
        if ({vn(0), vn(1), vn(2), vn(3)} !== {7'd70, 7'd71, 7'd73, 7'd65})
            $display("FAIL steal_notes: got %0d %0d %0d %0d, expected 70 71 73 65",
                     vn(0), vn(1), vn(2), vn(3));
        else pass_cnt++;
    endtask

    task automatic test_retrigger();
        do_reset();
        fill4(7'd64, 7'd62, 7'd60, 7'd65);
        ev(1'b1, 1'b0, 7'd60);
        total_cnt++;
        if ({voiceTrig_o, voiceGate_o, stealStrb_o} !== {4'b0100, 4'b1111, 1'b0})
            $display("FAIL retrig: got %b, expected 010011110",
                     {voiceTrig_o, voiceGate_o, stealStrb_o});
        else pass_cnt++;
        total_cnt++;
        if ({vn(0), vn(1), vn(2), vn(3)} !== {7'd64, 7'd62, 7'd60, 7'd65})
            $display("FAIL retrig_notes: got %0d %0d %0d %0d, expected 64 62 60 65",
                     vn(0), vn(1), vn(2), vn(3));
        else pass_cnt++;
        // Ages v0=3 v1=2 v2=0 v3=1: steal v0, then v1, then v3.
        ev(1'b1, 1'b0, 7'd80);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o} !== {4'b0001, 1'b1})
            $display("FAIL retrig_lru1: got %b, expected 00011", {voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        ev(1'b1, 1'b0, 7'd81);
        ev(1'b1, 1'b0, 7'd82);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o} !== {4'b1000, 1'b1})
            $display("FAIL retrig_lru3: got %b, expected 10001", {voiceTrig_o, stealStrb_o});
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        ev(1'b1, 1'b0, 7'd60);
        ev(1'b1, 1'b0, 7'd62);
        ev(1'b1, 1'b1, 7'd72);
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o} !== {4'b0111, 4'b0100})
            $display("FAIL on_off_same: got %b, expected 01110100", {voiceGate_o, voiceTrig_o});
        else pass_cnt++;
        ev(1'b0, 1'b1, 7'd65);
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o, vn(2)} !== {4'b0111, 4'b0000, 7'd72})
            $display("FAIL off_nomatch: got %b, expected gate 0111 trig 0000 note 72",
                     {voiceGate_o, voiceTrig_o, vn(2)});
        else pass_cnt++;
        // A released voice's stale note is not a match; lowest free voice wins.
        ev(1'b0, 1'b1, 7'd60);
        ev(1'b0, 1'b1, 7'd62);
        ev(1'b1, 1'b0, 7'd62);
        total_cnt++;
        if ({voiceTrig_o, voiceGate_o, vn(0)} !== {4'b0001, 4'b0101, 7'd62})
            $display("FAIL stale_retrig: got %b, expected trig 0001 gate 0101 note 62",
                     {voiceTrig_o, voiceGate_o, vn(0)});
        else pass_cnt++;
    endtask

    task automatic test_all_off_and_reset();
        do_reset();
        fill4(7'd60, 7'd62, 7'd64, 7'd65);
        allOff_i = 1'b1;
        ev(1'b1, 1'b0, 7'd50);
        allOff_i = 1'b0;
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o, stealStrb_o} !== 9'd0)
            $display("FAIL all_off: got %b, expected 0", {voiceGate_o, voiceTrig_o, stealStrb_o});
        else pass_cnt++;
        total_cnt++;
        if (vn(0) !== 7'd60) $display("FAIL all_off_note: got %0d, expected 60", vn(0));
        else pass_cnt++;
        ev(1'b1, 1'b0, 7'd50);
        total_cnt++;
        if ({voiceTrig_o, vn(0)} !== {4'b0001, 7'd50})
            $display("FAIL after_all_off: got %b, expected trig 0001 note 50", {voiceTrig_o, vn(0)});
        else pass_cnt++;
        // Asynchronous reset mid-operation, checked before any clock edge.
        #2;
        nrst_i = 1'b0;
        #1;
        total_cnt++;
        if ({voiceGate_o, voiceTrig_o, stealStrb_o, voiceNote_o} !== 37'd0)
            $display("FAIL async_reset: got gate %b note %h, expected 0", voiceGate_o, voiceNote_o);
        else pass_cnt++;
        @(negedge clk_i);
        nrst_i = 1'b1;
        @(posedge clk_i);
        #1;
        // Ages back to k: with four voices filled, the fifth note steals voice 3... no, voice 0
        // holds age 3 after four fills, so the steal lands on voice 0.
        fill4(7'd10, 7'd11, 7'd12, 7'd13);
        ev(1'b1, 1'b0, 7'd14);
        total_cnt++;
        if ({voiceTrig_o, stealStrb_o, vn(0)} !== {4'b0001, 1'b1, 7'd14})
            $display("FAIL reset_ages: got %b, expected trig 0001 steal 1 note 14",
                     {voiceTrig_o, stealStrb_o, vn(0)});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_free_reuse();
        test_steal();
        test_retrigger();
        test_simultaneous();
        test_all_off_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
